// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions. Both the receiver (uart_rx_mix) and the UartTX
//   block import this package.
//   - uart_state_e : frame state encoding IDLE=0, START=1, DATA=2, STOP=3
//   - uart_div()   : clocks per bit, CLK_HZ/BAUD with integer division
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic int unsigned uart_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_mix_if.sv
// ----------------------------------------------------------------------------
// uart_rx_mix_if
//   Byte handshake between the UART receiver and the MIX input device.
//   - data  : received byte, meaningful only while valid=1
//   - valid : byte available, held until accepted
//   - ack   : consumer takes the byte on a cycle with valid=1
//   Modports: master = receiver side, slave = consumer side.
// ----------------------------------------------------------------------------
interface uart_rx_mix_if;
    logic [7:0] data;
    logic       valid;
    logic       ack;

    modport master (output data, output valid, input ack);
    modport slave  (input data, input valid, output ack);
endinterface

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//   Small synchronous byte FIFO for the UART receiver.
//   Ports:
//     clk, reset : clock, asynchronous active-low reset (empties the FIFO)
//     push_i     : write din_i (ignored when full, unless pop_i in the same cycle)
//     din_i      : byte to write
//     pop_i      : remove the head entry (ignored when empty)
//     dout_o     : head entry
//     full_o     : DEPTH entries held
//     empty_o    : no entries held
//   DEPTH must be a power of two (>=2) so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned     PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_mix.sv
// ----------------------------------------------------------------------------
// uart_rx_mix
//   8N1 serial receiver (LSB first) feeding the MIX input device.
//   Ports:
//     clk       : system clock, rising edge
//     reset     : asynchronous active-low reset
//     rx        : serial line, idle high, asynchronous to clk
//     byte_if   : uart_rx_mix_if.master -- data / valid / ack handshake
//     frame_err : one-cycle pulse, stop bit sampled low
//     overrun   : one-cycle pulse, completed byte dropped (no storage free)
//     busy      : high while a frame is in progress
//   Build option: define UART_RX_FIFO_EN to buffer bytes in a FIFO_DEPTH-entry
//   FIFO (uart_rx_fifo); otherwise a single holding register is used.
// ----------------------------------------------------------------------------
module uart_rx_mix
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 12_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    uart_rx_mix_if.master  byte_if,
    output logic           frame_err,
    output logic           overrun,
    output logic           busy
);

    localparam int unsigned      DIV       = uart_div(CLK_HZ, BAUD);
    localparam int unsigned      CNT_W     = $clog2(DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // ---- rx synchronizer: two flops, preset to the idle level ----
    logic rx_meta_q;
    logic rxs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // ---- frame FSM: bit timing, shift register, busy / frame_err ----
    uart_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bitn_q;
    logic [7:0]       shreg_q;
    logic             busy_q;
    logic             frame_err_q;
    logic             byte_done;

    // Good stop bit this cycle: shreg_q already holds the complete byte.
    assign byte_done = (state_q == STOP) && (cnt_q == BIT_LAST) && rxs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitn_q      <= '0;
            shreg_q     <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rxs_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (rxs_q) begin
                            // Line back high at mid start bit: a glitch, not a frame.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                            bitn_q  <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shreg_q <= {rxs_q, shreg_q[7:1]};
                        bitn_q  <= bitn_q + 3'd1;
                        if (bitn_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        // Leave at mid stop bit so a back-to-back start edge is seen.
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        frame_err_q <= !rxs_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ---- byte storage and handshake ----
    logic overrun_q;

`ifdef UART_RX_FIFO_EN
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] fifo_head;

    assign fifo_pop  = byte_if.ack && !fifo_empty;
    assign fifo_push = byte_done && (!fifo_full || fifo_pop);

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .din_i   (shreg_q),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= byte_done && fifo_full && !fifo_pop;
        end
    end

    assign byte_if.data  = fifo_head;
    assign byte_if.valid = !fifo_empty;
`else
    logic [7:0] data_q;
    logic       valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (byte_done) begin
                // The register is free if empty or being drained this very cycle.
                if (!valid_q || byte_if.ack) begin
                    data_q  <= shreg_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && byte_if.ack) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign byte_if.data  = data_q;
    assign byte_if.valid = valid_q;
`endif

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
